// File: rtl/simd_reduce_engine.sv
// SIMD lane array feeding a radix-4 reduction tree, with multi-beat window accumulation.
// Four registered stages: lane op, L1 sums, L2 sums, beat total / accumulate / output load.
module simd_reduce_engine #(
  parameter int unsigned BW        = 8,
  parameter int unsigned LANES     = 64,
  parameter int unsigned ACC_BW    = 32,
  parameter int unsigned MAX_BEATS = 256,
  parameter int unsigned CNT_BW    = 9
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_mode,
  input  logic                           in_last,
  input  logic [BW*LANES-1:0]            iA,
  input  logic [BW*LANES-1:0]            iB,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [(2*BW+2)*(LANES/4)-1:0]  oL1,
  output logic [(2*BW+4)*(LANES/16)-1:0] oL2,
  output logic [ACC_BW-1:0]              oTotal,
  output logic [CNT_BW-1:0]              oBeats,
  output logic                           oSat,
  output logic                           oErr
);
  localparam int unsigned PW  = 2 * BW;
  localparam int unsigned L1W = PW + 2;
  localparam int unsigned L2W = PW + 4;
  localparam int unsigned G1  = LANES / 4;
  localparam int unsigned G2  = LANES / 16;
  localparam int unsigned TW  = L2W + $clog2(G2);
  // Sum width covers both operands so saturation is exact even if ACC_BW is undersized.
  localparam int unsigned SW  = ((ACC_BW > TW) ? ACC_BW : TW) + 1;
  localparam int unsigned MW  = CNT_BW + 2;

  localparam logic [1:0] MODE_MUL = 2'd0;
  localparam logic [1:0] MODE_ADD = 2'd1;
  localparam logic [1:0] MODE_MAX = 2'd2;

  logic              w_en, w_accept, w_first, w_err, w_last;
  logic [1:0]        w_mode;
  logic [CNT_BW-1:0] w_cnt;
  logic              r_open, r_err;
  logic [1:0]        r_mode;
  logic [CNT_BW-1:0] r_cnt;

  logic [LANES*PW-1:0] w_lane, r_lane;
  logic [G1*L1W-1:0]   w_l1, r_l1, r_l1_3;
  logic [G2*L2W-1:0]   w_l2, r_l2;
  logic [MW-1:0]       r_meta1, r_meta2, r_meta3;
  logic                r_v1, r_v2, r_v3;
  logic [TW-1:0]       w_btot;
  logic [SW-1:0]       w_sum;
  logic                w_ovf;
  logic [ACC_BW-1:0]   w_acc_next, r_acc;
  logic                r_sat;

  function automatic logic [PW-1:0] lane_op(input logic [1:0] m, input logic [BW-1:0] a,
                                            input logic [BW-1:0] b);
    case (m)
      MODE_MUL: lane_op = PW'(a) * PW'(b);
      MODE_ADD: lane_op = PW'(a) + PW'(b);
      MODE_MAX: lane_op = (a > b) ? PW'(a) : PW'(b);
      default:  lane_op = (a > b) ? PW'(a - b) : PW'(b - a);
    endcase
  endfunction

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_first  = !r_open;
  assign w_mode   = w_first ? in_mode : r_mode;
  assign w_err    = !w_first && (r_err || (in_mode != r_mode));
  assign w_cnt    = w_first ? CNT_BW'(1) : r_cnt + CNT_BW'(1);
  assign w_last   = in_last || (w_cnt == CNT_BW'(MAX_BEATS));

  // Window state: latched mode, mismatch flag and beat count of the open window.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_open <= 1'b0;
      r_err  <= 1'b0;
      r_mode <= 2'd0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_open <= !w_last;
      r_err  <= w_err;
      r_mode <= w_mode;
      r_cnt  <= w_cnt;
    end
  end

  always_comb begin
    w_lane = '0;
    for (int i = 0; i < int'(LANES); i++)
      w_lane[i*PW +: PW] = lane_op(w_mode, iA[i*BW +: BW], iB[i*BW +: BW]);
  end

  always_comb begin
    w_l1 = '0;
    for (int g = 0; g < int'(G1); g++)
      w_l1[g*L1W +: L1W] = L1W'(r_lane[(4*g)*PW +: PW]) + L1W'(r_lane[(4*g+1)*PW +: PW])
                         + L1W'(r_lane[(4*g+2)*PW +: PW]) + L1W'(r_lane[(4*g+3)*PW +: PW]);
  end

  always_comb begin
    w_l2 = '0;
    for (int g = 0; g < int'(G2); g++)
      w_l2[g*L2W +: L2W] = L2W'(r_l1[(4*g)*L1W +: L1W]) + L2W'(r_l1[(4*g+1)*L1W +: L1W])
                         + L2W'(r_l1[(4*g+2)*L1W +: L1W]) + L2W'(r_l1[(4*g+3)*L1W +: L1W]);
  end

  always_comb begin
    w_btot = '0;
    for (int g = 0; g < int'(G2); g++)
      w_btot = w_btot + TW'(r_l2[g*L2W +: L2W]);
  end

  assign w_sum      = SW'(r_acc) + SW'(w_btot);
  assign w_ovf      = |w_sum[SW-1:ACC_BW];
  assign w_acc_next = w_ovf ? '1 : w_sum[ACC_BW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else if (w_en) begin
      r_v1 <= w_accept;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
    end
  end

  // Datapath and beat tags {last, err, count} advance together; qualified by the valids.
  always_ff @(posedge clk) begin
    if (w_en) begin
      r_lane  <= w_lane;
      r_meta1 <= {w_last, w_err, w_cnt};
      r_l1    <= w_l1;
      r_meta2 <= r_meta1;
      r_l1_3  <= r_l1;
      r_l2    <= w_l2;
      r_meta3 <= r_meta2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc     <= '0;
      r_sat     <= 1'b0;
      out_valid <= 1'b0;
      oL1       <= '0;
      oL2       <= '0;
      oTotal    <= '0;
      oBeats    <= '0;
      oSat      <= 1'b0;
      oErr      <= 1'b0;
    end else if (w_en) begin
      out_valid <= r_v3 && r_meta3[MW-1];
      if (r_v3) begin
        if (r_meta3[MW-1]) begin
          r_acc  <= '0;
          r_sat  <= 1'b0;
          oL1    <= r_l1_3;
          oL2    <= r_l2;
          oTotal <= w_acc_next;
          oBeats <= r_meta3[CNT_BW-1:0];
          oSat   <= r_sat || w_ovf;
          oErr   <= r_meta3[CNT_BW];
        end else begin
          r_acc <= w_acc_next;
          r_sat <= r_sat || w_ovf;
        end
      end
    end
  end
endmodule

// File: tb/tb_simd_reduce_engine.sv
// Directed bench: a default engine and a small one (ACC_BW=16, MAX_BEATS=4) share stimulus.
module tb_simd_reduce_engine;
  localparam int unsigned BW     = 8;
  localparam int unsigned LANES  = 64;
  localparam int unsigned CNT_BW = 9;
  localparam int unsigned L1W    = 2*BW+2;
  localparam int unsigned L2W    = 2*BW+4;
  localparam int unsigned G1     = LANES/4;
  localparam int unsigned G2     = LANES/16;

  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready;
  logic [1:0] in_mode;
  logic [BW*LANES-1:0] iA, iB;

  logic in_ready1, out_valid1, oSat1, oErr1;
  logic [G1*L1W-1:0] oL1_1;
  logic [G2*L2W-1:0] oL2_1;
  logic [31:0] oTotal1;
  logic [CNT_BW-1:0] oBeats1;

  logic in_ready2, out_valid2, oSat2, oErr2;
  logic [G1*L1W-1:0] oL1_2;
  logic [G2*L2W-1:0] oL2_2;
  logic [15:0] oTotal2;
  logic [CNT_BW-1:0] oBeats2;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc;

  typedef struct {
    int cyc;
    longint unsigned l1, l2, tot;
    int unsigned beats;
    bit sat, err, l1eq, l2eq;
  } res_t;
  res_t q1[$], q2[$];

  simd_reduce_engine #(.BW(BW), .LANES(LANES), .ACC_BW(32), .MAX_BEATS(256), .CNT_BW(CNT_BW)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_mode(in_mode),
    .in_last(in_last), .iA(iA), .iB(iB), .out_valid(out_valid1), .out_ready(out_ready),
    .oL1(oL1_1), .oL2(oL2_1), .oTotal(oTotal1), .oBeats(oBeats1), .oSat(oSat1), .oErr(oErr1));

  simd_reduce_engine #(.BW(BW), .LANES(LANES), .ACC_BW(16), .MAX_BEATS(4), .CNT_BW(CNT_BW)) u_dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_mode(in_mode),
    .in_last(in_last), .iA(iA), .iB(iB), .out_valid(out_valid2), .out_ready(out_ready),
    .oL1(oL1_2), .oL2(oL2_2), .oTotal(oTotal2), .oBeats(oBeats2), .oSat(oSat2), .oErr(oErr2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t mk(input int c, input logic [G1*L1W-1:0] l1, input logic [G2*L2W-1:0] l2,
                              input logic [31:0] tot, input logic [CNT_BW-1:0] beats,
                              input logic sat, input logic err);
    res_t r;
    r.cyc = c; r.tot = tot; r.beats = beats; r.sat = sat; r.err = err;
    r.l1 = l1[L1W-1:0];
    r.l2 = l2[L2W-1:0];
    r.l1eq = 1'b1;
    r.l2eq = 1'b1;
    for (int i = 1; i < int'(G1); i++) if (l1[i*L1W +: L1W] != l1[L1W-1:0]) r.l1eq = 1'b0;
    for (int i = 1; i < int'(G2); i++) if (l2[i*L2W +: L2W] != l2[L2W-1:0]) r.l2eq = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (out_valid1 && out_ready) q1.push_back(mk(cyc, oL1_1, oL2_1, oTotal1, oBeats1, oSat1, oErr1));
    if (out_valid2 && out_ready) q2.push_back(mk(cyc, oL1_2, oL2_2, 32'(oTotal2), oBeats2, oSat2, oErr2));
  end

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive one beat with every lane equal; returns just after the accepting edge.
  task automatic send(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic [1:0] m,
                      input logic l);
    int guard = 0;
    in_valid = 1'b1; in_mode = m; in_last = l;
    iA = {LANES{a}}; iB = {LANES{b}};
    @(negedge clk);
    while (!(in_ready1 && in_ready2) && guard < 200) begin @(negedge clk); guard++; end
    check("send_accept", 64'(in_ready1 && in_ready2), 1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_q(input int n1, input int n2, input string tag);
    int guard = 0;
    while ((q1.size() < n1 || q2.size() < n2) && guard < 100) begin @(posedge clk); #1; guard++; end
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_count_big"}, 64'(q1.size()), 64'(n1));
    check({tag, "_count_small"}, 64'(q2.size()), 64'(n2));
  endtask

  task automatic clear_q();
    q1.delete();
    q2.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_last = 1'b0;
    iA = '0; iB = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready1), 0);
    check("rst_out_valid", 64'(out_valid1), 0);
    check("rst_total", 64'(oTotal1), 0);
    check("rst_beats", 64'(oBeats1), 0);
    check("rst_sat_err", 64'({oSat1, oErr1}), 0);
    check("rst_l1_l2", 64'((oL1_1 == '0) && (oL2_1 == '0)), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // single MUL beat: 2*3 per lane
    clear_q();
    send(8'd2, 8'd3, 2'd0, 1'b1);
    t = acc_cyc;
    wait_q(1, 1, "t1");
    if (q1.size() > 0) begin
      check("t1_latency", 64'(q1[0].cyc - t), 4);
      check("t1_l1", q1[0].l1, 24);
      check("t1_l1_all", 64'(q1[0].l1eq), 1);
      check("t1_l2", q1[0].l2, 96);
      check("t1_l2_all", 64'(q1[0].l2eq), 1);
      check("t1_total", q1[0].tot, 384);
      check("t1_beats", 64'(q1[0].beats), 1);
      check("t1_sat", 64'(q1[0].sat), 0);
      check("t1_err", 64'(q1[0].err), 0);
    end
    if (q2.size() > 0) check("t1_small_total", q2[0].tot, 384);

    // three ADD beats of 255+255
    clear_q();
    send(8'd255, 8'd255, 2'd1, 1'b0);
    send(8'd255, 8'd255, 2'd1, 1'b0);
    send(8'd255, 8'd255, 2'd1, 1'b1);
    wait_q(1, 1, "t2");
    if (q1.size() > 0) begin
      check("t2_total", q1[0].tot, 97920);
      check("t2_beats", 64'(q1[0].beats), 3);
      check("t2_l1", q1[0].l1, 2040);
      check("t2_l1_all", 64'(q1[0].l1eq), 1);
      check("t2_l2", q1[0].l2, 8160);
      check("t2_sat", 64'(q1[0].sat), 0);
    end
    if (q2.size() > 0) begin
      check("t2_small_total", q2[0].tot, 65535);
      check("t2_small_sat", 64'(q2[0].sat), 1);
    end

    // backpressure with three single-beat windows in flight
    clear_q();
    out_ready = 1'b0;
    send(8'd1, 8'd1, 2'd0, 1'b1);
    send(8'd1, 8'd2, 2'd1, 1'b1);
    send(8'd5, 8'd9, 2'd3, 1'b1);
    guard = 0;
    @(negedge clk);
    while (!out_valid1 && guard < 20) begin @(negedge clk); guard++; end
    check("t3_ov_rise", 64'(out_valid1), 1);
    for (int k = 0; k < 5; k++) begin
      check("t3_stall_in_ready", 64'(in_ready1), 0);
      check("t3_stall_ov", 64'(out_valid1), 1);
      check("t3_stall_total", 64'(oTotal1), 64);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_q(3, 3, "t3");
    if (q1.size() == 3) begin
      check("t3_total0", q1[0].tot, 64);
      check("t3_total1", q1[1].tot, 192);
      check("t3_total2", q1[2].tot, 256);
      check("t3_l1_2", q1[2].l1, 16);
      check("t3_beats2", 64'(q1[2].beats), 1);
    end

    // mode change inside a window: both beats computed as MUL
    clear_q();
    send(8'd1, 8'd4, 2'd0, 1'b0);
    send(8'd1, 8'd4, 2'd2, 1'b1);
    wait_q(1, 1, "t4");
    if (q1.size() > 0) begin
      check("t4_err", 64'(q1[0].err), 1);
      check("t4_total", q1[0].tot, 512);
      check("t4_beats", 64'(q1[0].beats), 2);
      check("t4_l1", q1[0].l1, 16);
    end

    // saturation on the 16-bit accumulator
    clear_q();
    send(8'd255, 8'd255, 2'd0, 1'b1);
    wait_q(1, 1, "t5");
    if (q2.size() > 0) begin
      check("t5_small_total", q2[0].tot, 65535);
      check("t5_small_sat", 64'(q2[0].sat), 1);
      check("t5_small_err", 64'(q2[0].err), 0);
    end
    if (q1.size() > 0) begin
      check("t5_total", q1[0].tot, 4161600);
      check("t5_sat", 64'(q1[0].sat), 0);
      check("t5_l1", q1[0].l1, 260100);
      check("t5_l2", q1[0].l2, 1040400);
    end

    // forced close at MAX_BEATS=4 on the small engine
    clear_q();
    for (int k = 0; k < 6; k++) send(8'd1, 8'd0, 2'd2, 1'b0);
    send(8'd1, 8'd0, 2'd2, 1'b1);
    wait_q(1, 2, "t6");
    if (q2.size() == 2) begin
      check("t6_small_beats0", 64'(q2[0].beats), 4);
      check("t6_small_total0", q2[0].tot, 256);
      check("t6_small_sat0", 64'(q2[0].sat), 0);
      check("t6_small_beats1", 64'(q2[1].beats), 3);
      check("t6_small_total1", q2[1].tot, 192);
    end
    if (q1.size() > 0) begin
      check("t6_beats", 64'(q1[0].beats), 7);
      check("t6_total", q1[0].tot, 448);
      check("t6_l1", q1[0].l1, 4);
    end

    // reset in the middle of an open window
    clear_q();
    send(8'd3, 8'd3, 2'd1, 1'b0);
    send(8'd3, 8'd3, 2'd1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rst_in_ready", 64'(in_ready1), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("t7_no_out_big", 64'(q1.size()), 0);
    check("t7_no_out_small", 64'(q2.size()), 0);
    send(8'd2, 8'd3, 2'd0, 1'b1);
    wait_q(1, 1, "t7");
    if (q1.size() > 0) begin
      check("t7_beats", 64'(q1[0].beats), 1);
      check("t7_total", q1[0].tot, 384);
      check("t7_err", 64'(q1[0].err), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/simd_reduce_engine.md
Name: simd_reduce_engine

Overview:
- Parametrised, pipelined SIMD lane array with a configurable number of lanes and a selectable per-lane operation.
- Each lane result feeds a radix-4 reduction tree that produces level-1 partial sums, level-2 partial sums and a grand total.
- Adds three behaviours the fixed 64-lane array lacks:
  - valid/ready handshakes on input and output;
  - multi-beat window accumulation with a beat counter;
  - saturation and error flags.
- Sits between the operand buffers and the post-processing/writeback stage.

Parameters:
- BW, 8: operand width per lane (unsigned).
- LANES, 64: lane count; must be 16·4^k (16, 64, 256).
- ACC_BW, 32: accumulator and total width; must be ≥ 2*BW+log2(LANES).
- MAX_BEATS, 256: maximum beats per window.
- CNT_BW, 9: beat counter width; must be ≥ log2(MAX_BEATS)+1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  engine can accept a beat
- in_mode  in  2  per-lane op: 0 MUL, 1 ADD, 2 MAX, 3 ABSDIFF
- in_last  in  1  beat closes the accumulation window
- iA  in  BW×LANES  operand A, one element per lane
- iB  in  BW×LANES  operand B, one element per lane
- out_valid  out  1  window result valid
- out_ready  in  1  downstream accepts the result
- oL1  out  (2*BW+2)×(LANES/4)  level-1 sums (groups of 4 lanes) of the window's final beat
- oL2  out  (2*BW+4)×(LANES/16)  level-2 sums (groups of 16 lanes) of the window's final beat
- oTotal  out  ACC_BW  grand total accumulated over all beats of the window
- oBeats  out  CNT_BW  number of beats in the window
- oSat  out  1  oTotal saturated
- oErr  out  1  a beat inside the window had a mode different from the window's first beat

Behaviour:
- Single clock clk; rst is synchronous, active-high.
- Reset:
  - clears all pipeline valids, the accumulator, the beat counter and all output registers (oL1/oL2/oTotal/oBeats = 0; out_valid/oSat/oErr = 0);
  - in_ready = 0 while rst is high;
  - asserting rst mid-window drops every in-flight beat and emits no out_valid.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en && !rst. A beat is accepted when in_valid && in_ready.
- When en = 0, every stage and every output register holds. No beat is lost or duplicated.
- Stages (all registered):
  - S1: per-lane op, result is 2*BW bits, zero-extended.
    - MUL = iA*iB
    - ADD = iA+iB
    - MAX = max(iA,iB)
    - ABSDIFF = |iA−iB|
  - S2: sum of each group of 4 lanes → L1.
  - S3: sum of each group of 4 L1 values → L2.
  - S4: sum of all L2 values → beat total. The beat total is added to the accumulator; output registers are loaded if the beat is last.
- Latency: a last beat accepted in cycle t produces out_valid in cycle t+4, provided there are no stalls.
- out_valid rises only for a last beat. It holds until the cycle where out_valid && out_ready, then clears unless a new last beat arrives in the same cycle.
- Windows:
  - The first beat after reset, or after a window closes, opens a window and latches its mode.
  - Later beats are computed with the latched mode. If a later beat's in_mode differs, oErr is set for that window.
  - The beat counter increments per accepted beat.
  - If the counter reaches MAX_BEATS with in_last = 0, that beat is treated as last and the window is force-closed; the next beat opens a new window.
- Accumulation:
  - acc_next = acc + beat_total, saturating at 2^ACC_BW−1; on saturation oSat is set for that window.
  - The accumulator clears when a last beat exits S4, so back-to-back windows do not mix.
- oL1/oL2 are the final beat's sums only. L1 and L2 never overflow by construction.
- Window state (latched mode, oErr tracking, beat counter) lives at the input stage. oSat is tracked at S4. Both travel with the beat's last tag.

Test Plan:
- LANES=64, BW=8; one beat, mode 0, all iA=2, iB=3, last=1 → out_valid at t+4; every oL1=24, every oL2=96, oTotal=384, oBeats=1, oSat=0, oErr=0.
- Three back-to-back beats, mode 1, iA=iB=255, last on beat 3 → single out_valid; oTotal=97920, oBeats=3, each oL1=2040.
- First result with out_ready=0 for 5 cycles while 2 more windows are in flight → in_ready=0, outputs stable; after release, results delivered in order with correct totals.
- Window opened in mode 0 (iA=1, iB=4), beat 2 in mode 2, last on beat 2 → oErr=1; oTotal=512 (both beats computed as MUL).
- ACC_BW=16, mode 0, iA=iB=255, 1 beat → oTotal=65535, oSat=1.
- MAX_BEATS=4, six beats with last=0 then one beat with last=1, mode 2, iA=1, iB=0 → first result oBeats=4, oTotal=256; second result oBeats=3, oTotal=192.
- rst asserted after 2 beats of an open window → no out_valid; the next single-beat window reports oBeats=1.
